sram_32x8: RTL and testbench

Synchronous single-port-per-direction 32-entry × 8-bit storage block with a separate write port and read port, each with its own request and done strobe. It is the on-chip scratch memory used by the surrounding datapath: a master raises `write` or `read` with an address, and the block performs the access on the next clock edge and acknowledges it. A synchronous reset clears the whole array.

---
 rtl/sram_pkg.sv | 15 +
 rtl/sram_array.sv | 45 ++++
 rtl/sram_32x8.sv | 70 +++++++
 tb/tb_sram_32x8.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared sizing constants and the address range check for the 32x8 scratch memory.
package sram_pkg;

  localparam int SRAM_DATA_W = 8;
  localparam int SRAM_DEPTH  = 32;
  localparam int SRAM_ADDR_W = 8;
  localparam int SRAM_IDX_W  = $clog2(SRAM_DEPTH);

  // True when the address does not name a real word. Any set bit above the
  // index field counts, so high addresses never alias onto low words.
  function automatic logic sram_out_of_range(input logic [SRAM_ADDR_W-1:0] addr);
    return addr >= SRAM_ADDR_W'(SRAM_DEPTH);
  endfunction

endpackage

// File: rtl/sram_array.sv
// Register array with one write port and one registered read port; the whole
// array and the read register are cleared by a synchronous reset.
module sram_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  input  logic              rzero,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage: clear every word on reset, otherwise apply the write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read register: samples the pre-write contents, so a same-cycle read of the
  // word being written returns the old value. Holds when no read is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= rzero ? '0 : mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sram_32x8.sv
// 32x8 scratch memory: request decoding, address range check and done strobes
// around the storage array.
module sram_32x8
  import sram_pkg::*;
#(
  parameter int DATA_W = SRAM_DATA_W,
  parameter int DEPTH  = SRAM_DEPTH,
  parameter int ADDR_W = SRAM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [ADDR_W-1:0] read_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              wr_done,
  output logic              rd_done
);

  localparam int IDX_W = $clog2(DEPTH);

  logic wr_oor;
  logic rd_oor;
  logic wr_done_d, wr_done_q;
  logic rd_done_d, rd_done_q;

  assign wr_oor = sram_out_of_range(write_addr);
  assign rd_oor = sram_out_of_range(read_addr);

  // Out-of-range writes are suppressed at the array but still acknowledged;
  // out-of-range reads are forced to return zero.
  sram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (write & ~wr_oor),
    .waddr (write_addr[IDX_W-1:0]),
    .wdata (wr_data),
    .re    (read),
    .raddr (read_addr[IDX_W-1:0]),
    .rzero (rd_oor),
    .rdata (rd_data)
  );

  // Every sampled request is acknowledged one cycle later, regardless of range.
  always_comb begin
    wr_done_d = write;
    rd_done_d = read;
  end

  // Done-strobe registers; reset drops any request sampled with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
    end else begin
      wr_done_q <= wr_done_d;
      rd_done_q <= rd_done_d;
    end
  end

  assign wr_done = wr_done_q;
  assign rd_done = rd_done_q;

endmodule

// File: tb/tb_sram_32x8.sv
// Self-checking bench for sram_32x8: a word-array model checked every cycle,
// plus directed vectors with literal expectations.
module tb_sram_32x8;

  logic       clk;
  logic       rst;
  logic       read;
  logic       write;
  logic [7:0] wr_data;
  logic [7:0] write_addr;
  logic [7:0] read_addr;
  logic [7:0] rd_data;
  logic       wr_done;
  logic       rd_done;

  int checks = 0;
  int fails  = 0;

  // model state
  int  model_mem [32];
  int  exp_rd_data;
  bit  exp_wr_done;
  bit  exp_rd_done;
  bit  model_ok = 0;

  sram_32x8 dut (
    .clk        (clk),
    .rst        (rst),
    .read       (read),
    .write      (write),
    .wr_data    (wr_data),
    .write_addr (write_addr),
    .read_addr  (read_addr),
    .rd_data    (rd_data),
    .wr_done    (wr_done),
    .rd_done    (rd_done)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Behavioural model: a plain array of words; reads see contents before the
  // same edge's write, out-of-range addresses read as zero and never store.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) model_mem[i] = 0;
      exp_rd_data = 0;
      exp_wr_done = 0;
      exp_rd_done = 0;
      model_ok = 1;
    end else begin
      exp_wr_done = write;
      exp_rd_done = read;
      if (read) exp_rd_data = (int'(read_addr) < 32) ? model_mem[read_addr] : 0;
      if (write && int'(write_addr) < 32) model_mem[write_addr] = int'(wr_data);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      checks++;
      if (int'(rd_data) != exp_rd_data) begin
        fails++;
        $display("FAIL model_rd_data t=%0t got=%02h want=%02h", $time, rd_data, exp_rd_data);
      end
      checks++;
      if (wr_done != exp_wr_done) begin
        fails++;
        $display("FAIL model_wr_done t=%0t got=%0b want=%0b", $time, wr_done, exp_wr_done);
      end
      checks++;
      if (rd_done != exp_rd_done) begin
        fails++;
        $display("FAIL model_rd_done t=%0t got=%0b want=%0b", $time, rd_done, exp_rd_done);
      end
    end
  end

  // Apply one cycle of inputs at the falling edge; return just after the
  // rising edge that samples them, so outputs reflect this step.
  task automatic step(input bit r, input bit w, input int wa, input int wd,
                      input bit rd, input int ra);
    @(negedge clk);
    rst        = r;
    write      = w;
    write_addr = 8'(wa);
    wr_data    = 8'(wd);
    read       = rd;
    read_addr  = 8'(ra);
    @(posedge clk);
    #1;
    $display("step rst=%0b wr=%0b wa=%0d wd=%02h rd=%0b ra=%0d -> rd_data=%02h wr_done=%0b rd_done=%0b",
             r, w, wa, wd, rd, ra, rd_data, wr_done, rd_done);
  endtask

  task automatic lit(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  initial begin
    rst = 1; read = 0; write = 0; wr_data = 0; write_addr = 0; read_addr = 0;

    // reset for two cycles
    step(1, 0, 0, 0, 0, 0);
    lit("rst1_wr_done", int'(wr_done), 0);
    lit("rst1_rd_done", int'(rd_done), 0);
    step(1, 1, 4, 8'h77, 1, 4);
    lit("rst2_wr_done", int'(wr_done), 0);
    lit("rst2_rd_done", int'(rd_done), 0);
    lit("rst2_rd_data", int'(rd_data), 0);

    // reads after reset
    step(0, 0, 0, 0, 1, 0);
    lit("rd0_data", int'(rd_data), 0);
    lit("rd0_done", int'(rd_done), 1);
    step(0, 0, 0, 0, 1, 7);
    lit("rd7_data", int'(rd_data), 0);
    step(0, 0, 0, 0, 1, 31);
    lit("rd31_data", int'(rd_data), 0);
    lit("rd31_done", int'(rd_done), 1);

    // write then read address 0
    step(0, 1, 0, 8'hFA, 0, 0);
    lit("wr0_done", int'(wr_done), 1);
    lit("wr0_rd_done", int'(rd_done), 0);
    step(0, 0, 0, 0, 1, 0);
    lit("rd0_fa", int'(rd_data), 8'hFA);
    lit("rd0_fa_done", int'(rd_done), 1);
    lit("rd0_fa_wr_done", int'(wr_done), 0);

    // reset clears memory
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 7, 350 % 256, 0, 0);
    step(0, 0, 0, 0, 1, 7);
    lit("rd7_5e", int'(rd_data), 8'h5E);
    step(0, 0, 0, 0, 1, 0);
    lit("rd0_cleared", int'(rd_data), 0);

    // simultaneous access to address 3
    step(0, 1, 3, 8'h11, 0, 0);
    step(0, 1, 3, 8'h22, 1, 3);
    lit("sim_rd_old", int'(rd_data), 8'h11);
    lit("sim_wr_done", int'(wr_done), 1);
    lit("sim_rd_done", int'(rd_done), 1);
    step(0, 0, 0, 0, 1, 3);
    lit("sim_rd_new", int'(rd_data), 8'h22);

    // idle cycle: rd_data holds, strobes drop
    step(0, 0, 0, 0, 0, 0);
    lit("idle_hold", int'(rd_data), 8'h22);
    lit("idle_rd_done", int'(rd_done), 0);

    // out-of-range write must not alias onto index 8
    step(0, 1, 8, 8'h33, 0, 0);
    step(0, 1, 40, 8'hAA, 0, 0);
    lit("oor_wr_done", int'(wr_done), 1);
    step(0, 0, 0, 0, 1, 40);
    lit("oor_rd_data", int'(rd_data), 0);
    lit("oor_rd_done", int'(rd_done), 1);
    step(0, 0, 0, 0, 1, 8);
    lit("rd8_unchanged", int'(rd_data), 8'h33);
    step(0, 0, 0, 0, 1, 255);
    lit("rd255_zero", int'(rd_data), 0);

    // reset during a held write
    step(0, 1, 9, 8'h44, 0, 0);
    lit("held1_wr_done", int'(wr_done), 1);
    step(1, 1, 9, 8'h55, 0, 0);
    lit("held2_wr_done", int'(wr_done), 0);
    step(0, 1, 9, 8'h66, 0, 0);
    lit("held3_wr_done", int'(wr_done), 1);
    step(0, 0, 0, 0, 1, 9);
    lit("held_rd9", int'(rd_data), 8'h66);
    step(0, 0, 0, 0, 1, 3);
    lit("held_rd3_cleared", int'(rd_data), 0);
    step(0, 0, 0, 0, 1, 8);
    lit("held_rd8_cleared", int'(rd_data), 0);

    // back-to-back writes and held reads at full throughput
    for (int i = 0; i < 6; i++) step(0, 1, 20 + i, 16 * i + 3, (i > 0), 19 + i);
    step(0, 0, 0, 0, 1, 25);
    lit("burst_rd25", int'(rd_data), 16 * 5 + 3);
    step(0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
